// File: rtl/alu_pkg.sv
// alu_pkg: shared op/state encodings and carry seeding for the digit-serial ALU
package alu_pkg;

    typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // SUB seeds 1 to complete the two's complement of the pre-inverted B
    function automatic logic carry_seed(op_t op, logic cin);
        return op == OP_ADD ? cin : op == OP_SUB;
    endfunction

endpackage

// File: rtl/alu_serial_if.sv
// alu_serial_if: operand/result valid-ready bundle of the serial ALU
interface alu_serial_if #(parameter int WIDTH = 64);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    op_t              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             zero;
    logic             ovf;

    modport master(output in_valid, a, b, cin, op, out_ready,
                   input in_ready, out_valid, s, cout, zero, ovf);
    modport slave(input in_valid, a, b, cin, op, out_ready,
                  output in_ready, out_valid, s, cout, zero, ovf);

endinterface

// File: rtl/alu_slice.sv
// alu_slice: one DIGIT-bit combinational ALU step shared by every chunk
module alu_slice
    import alu_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    input  op_t              op,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             c_msb
);

    logic [DIGIT:0] sum;
    logic           arith;

    assign sum   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, c_in};
    assign arith = op == OP_ADD || op == OP_SUB;
    assign s_d   = op == OP_AND ? a_d & b_d : op == OP_OR ? a_d | b_d : sum[DIGIT-1:0];
    assign c_out = arith & sum[DIGIT];
    // carry into the top bit recovered from its sum bit and operands
    assign c_msb = arith & (sum[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1]);

endmodule

// File: rtl/alu_serial.sv
// alu_serial: digit-serial AND/OR/ADD/SUB ALU, DIGIT bits per clock,
// with valid/ready handshakes on operands and result.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input logic         clk,
    input logic         rst,
    alu_serial_if.slave bus
);

    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int CW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("WIDTH must be a multiple of DIGIT");
    end

    state_t           state, nxt;
    logic [WIDTH-1:0] a_r, b_r, s_r, s_nxt;
    op_t              op_r;
    logic             c_r, cout_r, zero_r, ovf_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] s_d;
    logic             c_out, c_msb, last, accept;

    alu_slice #(.DIGIT(DIGIT)) u_slice (
        .a_d  (a_r[DIGIT-1:0]),
        .b_d  (b_r[DIGIT-1:0]),
        .c_in (c_r),
        .op   (op_r),
        .s_d  (s_d),
        .c_out(c_out),
        .c_msb(c_msb)
    );

    assign last   = cnt == CW'(NCHUNK - 1);
    assign accept = state == IDLE && bus.in_valid;
    // each new digit enters at the top; after NCHUNK steps the first one sits at bit 0
    assign s_nxt  = WIDTH'({s_d, s_r} >> DIGIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.in_valid ? RUN : IDLE;
            RUN:     nxt = last ? DONE : RUN;
            DONE:    nxt = bus.out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            s_r    <= '0;
            op_r   <= OP_AND;
            c_r    <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            a_r  <= bus.a;
            b_r  <= bus.op == OP_SUB ? ~bus.b : bus.b;
            op_r <= bus.op;
            c_r  <= carry_seed(bus.op, bus.cin);
            cnt  <= '0;
        end else if (state == RUN) begin
            a_r <= a_r >> DIGIT;
            b_r <= b_r >> DIGIT;
            s_r <= s_nxt;
            c_r <= c_out;
            cnt <= cnt + CW'(1);
            if (last) begin
                cout_r <= c_out;
                ovf_r  <= c_msb ^ c_out;
                zero_r <= s_nxt == '0;
            end
        end
    end

    assign bus.s    = s_r;
    assign bus.cout = cout_r;
    assign bus.zero = zero_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed vectors and handshake corners on DIGIT=8, plus a
// random sweep over DIGIT 1/8/64 checked against a behavioural model.
module tb_alu_serial;
    import alu_pkg::*;

    localparam int W = 64;

    typedef struct {
        op_t          op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         zero;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         zero;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_fail = 0;
    logic sweep = 1'b0;
    int   sweep_done = 0;

    logic         d_iv = 1'b0, d_cin = 1'b0, d_ordy = 1'b0;
    logic [W-1:0] d_a = '0, d_b = '0;
    op_t          d_op = OP_AND;

    res_t q8[$];
    int   acc8 = 0;
    vec_t tv[10];

    alu_serial_if #(.WIDTH(W)) bus[3] ();

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic res_t model(op_t op, logic [W-1:0] a, logic [W-1:0] b, logic cin);
        res_t     r;
        logic [W:0] t;
        r.s    = '0;
        r.cout = 1'b0;
        r.ovf  = 1'b0;
        case (op)
            OP_AND: r.s = a & b;
            OP_OR:  r.s = a | b;
            OP_ADD: begin
                t      = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
                r.s    = t[W-1:0];
                r.cout = t[W];
                r.ovf  = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
            end
            default: begin
                t      = {1'b0, a} + {1'b0, ~b} + (W + 1)'(1);
                r.s    = t[W-1:0];
                r.cout = t[W];
                r.ovf  = (a[W-1] != b[W-1]) && (r.s[W-1] != a[W-1]);
            end
        endcase
        r.zero = r.s == '0;
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(7))
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D    = g == 0 ? 1 : g == 1 ? 8 : 64;
        localparam int NOPS = g == 0 ? 300 : 1000;

        logic         sw_iv = 1'b0, sw_cin = 1'b0, sw_ordy = 1'b0;
        logic [W-1:0] sw_a = '0, sw_b = '0;
        op_t          sw_op = OP_AND;
        res_t         q[$];

        assign bus[g].in_valid  = sweep ? sw_iv : d_iv;
        assign bus[g].a         = sweep ? sw_a : d_a;
        assign bus[g].b         = sweep ? sw_b : d_b;
        assign bus[g].cin       = sweep ? sw_cin : d_cin;
        assign bus[g].op        = sweep ? sw_op : d_op;
        assign bus[g].out_ready = sweep ? sw_ordy : d_ordy;

        alu_serial #(.WIDTH(W), .DIGIT(D)) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus[g])
        );

        initial begin : sweep_proc
            int   acc;
            int   n;
            res_t e;
            wait (sweep);
            for (int k = 0; k < NOPS; k++) begin
                @(negedge clk);
                sw_op  = op_t'($urandom_range(3));
                sw_a   = pick();
                sw_b   = pick();
                sw_cin = 1'($urandom_range(1));
                sw_iv  = 1'b1;
                chk("sweep_in_ready", 64'(bus[g].in_ready), 64'd1);
                q.push_back(model(sw_op, sw_a, sw_b, sw_cin));
                @(posedge clk);
                #1;
                acc   = cyc;
                sw_iv = 1'b0;
                n = 0;
                @(negedge clk);
                while (!bus[g].out_valid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("sweep_latency", 64'(cyc - acc), 64'(W / D));
                e = q.pop_front();
                chk("sweep_s", bus[g].s, e.s);
                chk("sweep_cout", 64'(bus[g].cout), 64'(e.cout));
                chk("sweep_zero", 64'(bus[g].zero), 64'(e.zero));
                chk("sweep_ovf", 64'(bus[g].ovf), 64'(e.ovf));
                repeat ($urandom_range(2)) @(negedge clk);
                chk("sweep_hold_s", bus[g].s, e.s);
                sw_ordy = 1'b1;
                @(posedge clk);
                #1 sw_ordy = 1'b0;
            end
            sweep_done++;
        end
    end

    task automatic send8(op_t op, logic [W-1:0] a, logic [W-1:0] b, logic cin);
        @(negedge clk);
        d_op  = op;
        d_a   = a;
        d_b   = b;
        d_cin = cin;
        d_iv  = 1'b1;
        chk("in_ready_idle", 64'(bus[1].in_ready), 64'd1);
        @(posedge clk);
        #1;
        acc8 = cyc;
        d_iv = 1'b0;
    endtask

    task automatic wait8();
        int n = 0;
        @(negedge clk);
        while (!bus[1].out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(cyc - acc8), 64'd8);
    endtask

    task automatic cmp8(string t);
        res_t e = q8.pop_front();
        chk({t, "_valid"}, 64'(bus[1].out_valid), 64'd1);
        chk({t, "_s"}, bus[1].s, e.s);
        chk({t, "_cout"}, 64'(bus[1].cout), 64'(e.cout));
        chk({t, "_zero"}, 64'(bus[1].zero), 64'(e.zero));
        chk({t, "_ovf"}, 64'(bus[1].ovf), 64'(e.ovf));
    endtask

    task automatic ack8();
        d_ordy = 1'b1;
        @(posedge clk);
        #1 d_ordy = 1'b0;
    endtask

    initial begin
        tv[0] = '{OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0};
        tv[1] = '{OP_SUB, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1};
        tv[2] = '{OP_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'hF000_F000_F000_F000, 1'b0, 1'b0, 1'b0};
        tv[3] = '{OP_OR, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'hFFF0_FFF0_FFF0_FFF0, 1'b0, 1'b0, 1'b0};
        tv[4] = '{OP_ADD, 64'd5, 64'd7, 1'b1, 64'd13, 1'b0, 1'b0, 1'b0};
        tv[5] = '{OP_SUB, 64'd5, 64'd5, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0};
        tv[6] = '{OP_SUB, 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tv[7] = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1};
        tv[8] = '{OP_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1};
        tv[9] = '{OP_SUB, 64'd10, 64'd3, 1'b1, 64'd7, 1'b1, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(bus[1].in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus[1].out_valid), 64'd0);
        chk("rst_s", bus[1].s, 64'd0);
        chk("rst_flags", {61'd0, bus[1].cout, bus[1].zero, bus[1].ovf}, 64'd0);
        rst = 1'b0;

        d_ordy = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ordy_valid", 64'(bus[1].out_valid), 64'd0);
        chk("idle_ordy_ready", 64'(bus[1].in_ready), 64'd1);
        d_ordy = 1'b0;

        for (int i = 0; i < 10; i++) begin
            q8.push_back('{tv[i].s, tv[i].cout, tv[i].zero, tv[i].ovf});
            send8(tv[i].op, tv[i].a, tv[i].b, tv[i].cin);
            wait8();
            cmp8($sformatf("vec%0d", i));
            ack8();
        end

        // back-pressure with in_valid pulsed during RUN and held through DONE
        q8.push_back('{64'd13, 1'b0, 1'b0, 1'b0});
        send8(OP_ADD, 64'd5, 64'd7, 1'b1);
        @(negedge clk);
        d_op = OP_SUB;
        d_a  = 64'd100;
        d_b  = 64'd1;
        d_iv = 1'b1;
        chk("run_in_ready", 64'(bus[1].in_ready), 64'd0);
        wait8();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(bus[1].out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus[1].in_ready), 64'd0);
            chk("bp_s", bus[1].s, 64'd13);
        end
        cmp8("bp");
        d_op  = OP_ADD;
        d_a   = 64'd1;
        d_b   = 64'd2;
        d_cin = 1'b0;
        q8.push_back('{64'd3, 1'b0, 1'b0, 1'b0});
        ack8();
        chk("release_in_ready", 64'(bus[1].in_ready), 64'd1);
        chk("release_out_valid", 64'(bus[1].out_valid), 64'd0);
        @(posedge clk);
        #1;
        acc8 = cyc;
        d_iv = 1'b0;
        chk("next_accepted", 64'(bus[1].in_ready), 64'd0);
        wait8();
        cmp8("after_bp");
        ack8();

        // asynchronous reset at RUN chunk 3 discards the partial result
        send8(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_1111_1111_1111, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(bus[1].out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus[1].in_ready), 64'd1);
        chk("midrst_s", bus[1].s, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        q8.push_back('{64'd13, 1'b0, 1'b0, 1'b0});
        send8(OP_ADD, 64'd5, 64'd7, 1'b1);
        wait8();
        cmp8("after_rst");
        ack8();

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sweep = 1'b1;
        for (int i = 0; i < 60000 && sweep_done < 3; i++) @(negedge clk);
        chk("sweep_complete", 64'(sweep_done), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
